rcv_ctrl: RTL and testbench

//  Receiver control unit for the UART RX path. Synchronises the raw serial line, detects the start bit and

---
 rtl/rcv_ctrl_pkg.sv | 9 +
 rtl/rcv_ctrl_if.sv | 29 ++
 rtl/rcv_ctrl_start_bit_det.sv | 40 ++++
 rtl/rcv_ctrl.sv | 83 ++++++++
 tb/tb_rcv_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/rcv_ctrl_pkg.sv
// UART RX control: shared state encoding and reset constants.
package rx_pkg;
  typedef enum logic [2:0] {
    IDLE, CLEAR, RECEIVE, STOPWAIT,
    CHECK, LOAD, FRAMEERR
  } rcv_state_t;

  localparam logic SYNC_RESET_VAL = 1'b1;
endpackage

// File: rtl/rcv_ctrl_if.sv
// UART RX control: line, timer and host-side signal bundle.
interface rcv_ctrl_if;
  logic serial_in;
  logic packet_done;
  logic stop_bit;
  logic data_read;
  logic enable_timer;
  logic sbc_clear;
  logic load_buffer;
  logic data_ready;
  logic framing_error;
  logic overrun_error;

  modport master (
    output serial_in, packet_done,
    output stop_bit, data_read,
    input  enable_timer, sbc_clear,
    input  load_buffer, data_ready,
    input  framing_error, overrun_error
  );

  modport slave (
    input  serial_in, packet_done,
    input  stop_bit, data_read,
    output enable_timer, sbc_clear,
    output load_buffer, data_ready,
    output framing_error, overrun_error
  );
endinterface

// File: rtl/rcv_ctrl_start_bit_det.sv
// UART RX control: serial line synchroniser and start-edge detector.
module start_bit_det
  import rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  output logic start_edge
);

  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] filled;
  logic                   prev;
  logic                   armed;
  logic                   sync_out;

  assign sync_out = sync[SYNC_STAGES-1];

  // armed only once a real high has crossed the chain, so a line
  // held low through reset cannot look like a fresh falling edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= {SYNC_STAGES{SYNC_RESET_VAL}};
      filled <= '0;
      prev   <= SYNC_RESET_VAL;
      armed  <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], serial_in};
      filled <= {filled[SYNC_STAGES-2:0], 1'b1};
      prev   <= sync_out;
      if (filled[SYNC_STAGES-1] && sync_out)
        armed <= 1'b1;
    end
  end

  assign start_edge = armed & prev & ~sync_out;

endmodule

// File: rtl/rcv_ctrl.sv
// UART RX control: frame sequencing FSM and host status flags.
module rcv_ctrl
  import rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  rcv_ctrl_if.slave  bus
);

  rcv_state_t state;
  rcv_state_t state_nx;
  logic       start_edge;
  logic       ready_q;
  logic       frame_q;
  logic       overrun_q;

  start_bit_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_det (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (bus.serial_in),
    .start_edge (start_edge)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx         = state;
    bus.enable_timer = 1'b0;
    bus.sbc_clear    = 1'b0;
    bus.load_buffer  = 1'b0;
    unique case (state)
      IDLE:     if (start_edge) state_nx = CLEAR;
      CLEAR: begin
        bus.sbc_clear = 1'b1;
        state_nx      = RECEIVE;
      end
      RECEIVE: begin
        bus.enable_timer = 1'b1;
        if (bus.packet_done) state_nx = STOPWAIT;
      end
      STOPWAIT: state_nx = CHECK;
      CHECK:    state_nx = bus.stop_bit ? LOAD : FRAMEERR;
      LOAD: begin
        bus.load_buffer = 1'b1;
        state_nx        = IDLE;
      end
      FRAMEERR: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // a read coinciding with LOAD acknowledges the old word only
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q   <= 1'b0;
      frame_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (state == CLEAR)         frame_q <= 1'b0;
      else if (state == FRAMEERR) frame_q <= 1'b1;
      if (state == LOAD) begin
        ready_q <= 1'b1;
        if (ready_q && !bus.data_read)
          overrun_q <= 1'b1;
      end else if (bus.data_read) begin
        ready_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.data_ready    = ready_q;
  assign bus.framing_error = frame_q;
  assign bus.overrun_error = overrun_q;

endmodule

// File: tb/tb_rcv_ctrl.sv
// UART RX control: directed vector table plus multi-cycle frame sequences.
module tb_rcv_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  rcv_ctrl_if bus();

  rcv_ctrl #(
    .SYNC_STAGES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // expected order: {en, clr, ld, ready, ferr, ovr}
  typedef struct {
    logic       rst;
    logic       ser;
    logic       pd;
    logic       sb;
    logic       rd;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [5:0] outs();
    return {bus.enable_timer, bus.sbc_clear,
            bus.load_buffer, bus.data_ready,
            bus.framing_error, bus.overrun_error};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n,
                     input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  n, act, exp);
  endtask

  task automatic start_frame(input string n);
    int lat;
    bit seen;
    bus.serial_in = 1'b1;
    repeat (4) step();
    bus.serial_in = 1'b0;
    lat  = 0;
    seen = 0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      step();
      if (bus.sbc_clear) begin
        seen = 1;
        lat  = i;
      end
    end
    chk({n, "_start_lat"}, lat, 3);
    step();
    chk({n, "_clr_en"}, {bus.sbc_clear, bus.enable_timer}, 2'b01);
    chk({n, "_ferr_cleared"}, bus.framing_error, 0);
  endtask

  task automatic finish_frame(input string n, input bit sb,
                              input bit rd, input bit glitch);
    int en_cnt;
    en_cnt = 0;
    for (int i = 1; i <= 90; i++) begin
      if (bus.enable_timer) en_cnt++;
      if (i == 2) bus.serial_in = 1'b1;
      if (glitch && i == 10) bus.serial_in = 1'b0;
      if (glitch && i == 15) bus.serial_in = 1'b1;
      if (i == 90) bus.packet_done = 1'b1;
      step();
    end
    bus.packet_done = 1'b0;
    bus.stop_bit    = sb;
    bus.serial_in   = 1'b1;
    chk({n, "_en_cycles"}, en_cnt, 90);
    chk({n, "_stopwait"}, {bus.enable_timer, bus.load_buffer}, 2'b00);
    step();
    chk({n, "_check_ld"}, bus.load_buffer, 0);
    step();
    chk({n, "_load"}, bus.load_buffer, int'(sb));
    bus.data_read = rd;
    step();
    bus.data_read = 1'b0;
    chk({n, "_idle"}, {bus.load_buffer, bus.enable_timer}, 2'b00);
  endtask

  initial begin
    int hits;
    rst             = 1'b1;
    bus.serial_in   = 1'b1;
    bus.packet_done = 1'b0;
    bus.stop_bit    = 1'b0;
    bus.data_read   = 1'b0;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b010000};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b100000};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b100000};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000000};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000000};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b001000};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000100};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'b000000};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000};

    for (int i = 0; i < 15; i++) begin
      rst             = tbl[i].rst;
      bus.serial_in   = tbl[i].ser;
      bus.packet_done = tbl[i].pd;
      bus.stop_bit    = tbl[i].sb;
      bus.data_read   = tbl[i].rd;
      step();
      chk($sformatf("vec%0d", i), int'(outs()), int'(tbl[i].exp));
    end
    bus.packet_done = 1'b0;
    bus.data_read   = 1'b0;
    bus.stop_bit    = 1'b0;

    start_frame("good");
    finish_frame("good", 1'b1, 1'b0, 1'b0);
    chk("good_flags", int'(outs()), 6'b000100);

    start_frame("ovr");
    finish_frame("ovr", 1'b1, 1'b0, 1'b0);
    chk("ovr_flags", int'(outs()), 6'b000101);
    bus.data_read = 1'b1;
    step();
    bus.data_read = 1'b0;
    chk("ovr_read", int'(outs()), 6'b000000);

    start_frame("bad");
    finish_frame("bad", 1'b0, 1'b0, 1'b0);
    chk("bad_flags", int'(outs()), 6'b000010);
    bus.data_read = 1'b1;
    step();
    bus.data_read = 1'b0;
    chk("bad_read_noeff", int'(outs()), 6'b000010);

    start_frame("after_bad");
    finish_frame("after_bad", 1'b1, 1'b0, 1'b1);
    chk("after_bad_flags", int'(outs()), 6'b000100);

    start_frame("coinc");
    finish_frame("coinc", 1'b1, 1'b1, 1'b0);
    chk("coinc_flags", int'(outs()), 6'b000100);

    bus.packet_done = 1'b1;
    step();
    bus.packet_done = 1'b0;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.enable_timer || bus.sbc_clear || bus.load_buffer)
        hits++;
      step();
    end
    chk("idle_pd_ignored", hits, 0);
    chk("idle_pd_flags", int'(outs()), 6'b000100);

    start_frame("rst");
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_outs", int'(outs()), 6'b000000);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.sbc_clear || bus.enable_timer) hits++;
    end
    chk("rst_break_nostart", hits, 0);

    start_frame("post_rst");
    finish_frame("post_rst", 1'b1, 1'b0, 1'b0);
    chk("post_rst_flags", int'(outs()), 6'b000100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
